// File: rtl/tclock_pkg.sv
// Shared types and default widths for the emulated-clock generator.
package tclock_pkg;

  localparam int unsigned CW_DEF = 16;
  localparam int unsigned NW_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } tstate_e;

endpackage

// File: rtl/tclock_gen_phase_counter.sv
// Loadable down-counter timing one phase of T; expire_o is high on the last
// U cycle of the phase.
module phase_counter
  import tclock_pkg::*;
#(
  parameter int unsigned CW = CW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          load_i,
  input  logic [CW-1:0] len_i,
  output logic          expire_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Loading max(len,1)-1 gives a phase of exactly max(len,1) cycles, so 0 and 1 coincide.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = (len_i == '0) ? '0 : len_i - CW'(1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/tclock_gen.sv
// Emulated processor clock generator: free-running or single-stepped T with
// programmable high/low widths and a completed-cycle counter.
//
//   state | meaning
//   IDLE  | T low, waiting for run or step_req
//   HIGH  | T high, timing the latched high length
//   LOW   | T low, timing the latched low length; cycle completes on expiry
module tclock_gen
  import tclock_pkg::*;
#(
  parameter int unsigned CW = CW_DEF,
  parameter int unsigned NW = NW_DEF
) (
  input  logic          U,
  input  logic          _RESET,
  input  logic          run,
  input  logic          step_req,
  input  logic [CW-1:0] hi_len,
  input  logic [CW-1:0] lo_len,
  output logic          T,
  output logic          _T,
  output logic          busy,
  output logic          step_done,
  output logic [NW-1:0] ncycles
);

  tstate_e       state_q;
  logic          t_q, t_n_q, busy_q, step_done_q, stepping_q;
  logic [CW-1:0] lo_sh_q;
  logic [NW-1:0] ncycles_q;

  logic          expire;
  logic          start_idle, cyc_end, go_high, go_low;
  logic          ctr_load;
  logic [CW-1:0] ctr_len;

  always_comb begin
    start_idle = (state_q == ST_IDLE) && (run || step_req);
    cyc_end    = (state_q == ST_LOW) && expire;
    go_high    = start_idle || (cyc_end && !stepping_q && run);
    go_low     = (state_q == ST_HIGH) && expire;
    ctr_load   = go_high || go_low;
    ctr_len    = go_high ? hi_len : lo_sh_q;
  end

  // The counter captures the high length directly, so only the low length needs a shadow.
  phase_counter #(.CW(CW)) u_phase (
    .clk_i    (U),
    .rst_n_i  (_RESET),
    .load_i   (ctr_load),
    .len_i    (ctr_len),
    .expire_o (expire)
  );

  always_ff @(posedge U or negedge _RESET) begin
    if (!_RESET) begin
      state_q     <= ST_IDLE;
      t_q         <= 1'b0;
      t_n_q       <= 1'b1;
      busy_q      <= 1'b0;
      step_done_q <= 1'b0;
      stepping_q  <= 1'b0;
      lo_sh_q     <= '0;
      ncycles_q   <= '0;
    end else begin
      step_done_q <= cyc_end && stepping_q;
      if (cyc_end) begin
        ncycles_q <= ncycles_q + NW'(1);
      end
      if (go_high) begin
        lo_sh_q <= lo_len;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (start_idle) begin
            state_q    <= ST_HIGH;
            t_q        <= 1'b1;
            t_n_q      <= 1'b0;
            busy_q     <= 1'b1;
            stepping_q <= !run;
          end
        end
        ST_HIGH: begin
          if (expire) begin
            state_q <= ST_LOW;
            t_q     <= 1'b0;
            t_n_q   <= 1'b1;
          end
        end
        ST_LOW: begin
          if (expire) begin
            stepping_q <= 1'b0;
            if (go_high) begin
              state_q <= ST_HIGH;
              t_q     <= 1'b1;
              t_n_q   <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          t_q        <= 1'b0;
          t_n_q      <= 1'b1;
          busy_q     <= 1'b0;
          stepping_q <= 1'b0;
        end
      endcase
    end
  end

  assign T         = t_q;
  assign _T        = t_n_q;
  assign busy      = busy_q;
  assign step_done = step_done_q;
  assign ncycles   = ncycles_q;

endmodule

// File: tb/tb_tclock_gen.sv
// Scoreboard bench for tclock_gen: stimulus queues the expected shape of each
// T cycle, a negedge monitor measures the cycles the DUT produces.
module tb_tclock_gen;

  logic        U = 1'b0;
  logic        _RESET = 1'b0;
  logic        run = 1'b0;
  logic        step_req = 1'b0;
  logic [15:0] hi_len = '0;
  logic [15:0] lo_len = '0;

  logic        T, _T, busy, step_done;
  logic [31:0] ncycles;
  logic        w_T, w_Tn, w_busy, w_step_done;
  logic [3:0]  w_ncycles;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int hi;
    int lo;
    bit step;
    int ncyc;
  } rec_t;

  rec_t exp_q[$];
  int   mon_hi = 0;
  int   mon_lo = 0;

  tclock_gen dut (
    .U(U), ._RESET(_RESET), .run(run), .step_req(step_req),
    .hi_len(hi_len), .lo_len(lo_len),
    .T(T), ._T(_T), .busy(busy), .step_done(step_done), .ncycles(ncycles)
  );

  tclock_gen #(.NW(4)) dut_w (
    .U(U), ._RESET(_RESET), .run(run), .step_req(step_req),
    .hi_len(hi_len), .lo_len(lo_len),
    .T(w_T), ._T(w_Tn), .busy(w_busy), .step_done(w_step_done), .ncycles(w_ncycles)
  );

  always #5 U = ~U;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge U);
    #1;
  endtask

  task automatic push(input int h, input int l, input bit s, input int n);
    rec_t r;
    r.hi = h; r.lo = l; r.step = s; r.ncyc = n;
    exp_q.push_back(r);
  endtask

  task automatic do_reset();
    run = 1'b0;
    step_req = 1'b0;
    _RESET = 1'b0;
    tick();
    tick();
    _RESET = 1'b1;
    tick();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    chk({name, " pending cycles"}, exp_q.size(), 0);
    tick();
    tick();
  endtask

  // Monitor: a cycle is a run of T=1 samples followed by T=0 samples while busy.
  always @(negedge U) begin
    rec_t r;
    if (!_RESET) begin
      mon_hi = 0;
      mon_lo = 0;
    end else begin
      chk("T vs _T complement", T ^ _T, 1);
      chk("narrow build T vs _T", w_T ^ w_Tn, 1);
      chk("narrow build busy", w_busy, busy);
      chk("narrow build step_done", w_step_done, step_done);
      if (mon_lo > 0 && (T || !busy)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected completed cycle", 1, 0);
        end else begin
          r = exp_q.pop_front();
          chk("cycle high width", mon_hi, r.hi);
          chk("cycle low width", mon_lo, r.lo);
          chk("step_done at completion", step_done, r.step);
          chk("ncycles at completion", ncycles, r.ncyc);
        end
        mon_hi = 0;
        mon_lo = 0;
      end else if (step_done) begin
        chk("step_done outside completion", step_done, 0);
      end
      if (T) mon_hi++;
      else if (busy) mon_lo++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    // Reset values
    tick();
    chk("reset T", T, 0);
    chk("reset _T", _T, 1);
    chk("reset busy", busy, 0);
    chk("reset step_done", step_done, 0);
    chk("reset ncycles", ncycles, 0);
    _RESET = 1'b1;
    tick();

    // Free-running 3/5
    hi_len = 16'd3; lo_len = 16'd5;
    for (int k = 1; k <= 5; k++) push(3, 5, 1'b0, k);
    run = 1'b1;
    repeat (40) tick();
    run = 1'b0;
    drain("run 3/5");
    chk("run 3/5 ncycles", ncycles, 5);
    chk("run 3/5 busy", busy, 0);

    // Single step 2/2
    do_reset();
    hi_len = 16'd2; lo_len = 16'd2;
    push(2, 2, 1'b1, 1);
    step_req = 1'b1;
    tick();
    chk("step T at n+1", T, 1);
    chk("step busy at n+1", busy, 1);
    step_req = 1'b0;
    tick();
    chk("step T at n+2", T, 1);
    tick();
    chk("step T at n+3", T, 0);
    chk("step busy at n+3", busy, 1);
    tick();
    chk("step T at n+4", T, 0);
    tick();
    chk("step_done at n+5", step_done, 1);
    chk("step busy at n+5", busy, 0);
    chk("step ncycles at n+5", ncycles, 1);
    tick();
    chk("step_done one cycle", step_done, 0);
    drain("step 2/2");

    // Zero lengths, lo_len changed mid-HIGH
    do_reset();
    hi_len = 16'd0; lo_len = 16'd0;
    for (int k = 1; k <= 4; k++) push(1, 1, 1'b0, k);
    push(1, 3, 1'b0, 5);
    run = 1'b1;
    repeat (7) tick();
    lo_len = 16'd3;
    repeat (5) tick();
    run = 1'b0;
    drain("zero lengths");
    chk("zero lengths ncycles", ncycles, 5);

    // run dropped early in HIGH, step_req ignored while busy
    do_reset();
    hi_len = 16'd4; lo_len = 16'd4;
    push(4, 4, 1'b0, 1);
    run = 1'b1;
    tick();
    tick();
    run = 1'b0;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    drain("run drop");
    repeat (12) tick();
    chk("run drop ncycles", ncycles, 1);
    chk("run drop busy", busy, 0);

    // Async reset mid-LOW
    do_reset();
    hi_len = 16'd1; lo_len = 16'd3;
    push(1, 3, 1'b0, 1);
    run = 1'b1;
    repeat (7) tick();
    chk("pre-reset ncycles", ncycles, 1);
    chk("pre-reset T in LOW", T, 0);
    chk("pre-reset busy", busy, 1);
    run = 1'b0;
    _RESET = 1'b0;
    #1;
    chk("async reset T", T, 0);
    chk("async reset _T", _T, 1);
    chk("async reset ncycles", ncycles, 0);
    chk("async reset busy", busy, 0);
    chk("async reset step_done", step_done, 0);
    tick();
    tick();
    _RESET = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post-reset T stays low", T, 0);
    end
    push(1, 3, 1'b0, 1);
    run = 1'b1;
    tick();
    chk("post-reset first T rise", T, 1);
    run = 1'b0;
    drain("post-reset");
    chk("post-reset ncycles", ncycles, 1);

    // run and step_req together: run wins, no step_done
    do_reset();
    hi_len = 16'd1; lo_len = 16'd1;
    push(1, 1, 1'b0, 1);
    run = 1'b1;
    step_req = 1'b1;
    tick();
    run = 1'b0;
    step_req = 1'b0;
    drain("run+step");

    // run rising during a stepped cycle
    push(1, 1, 1'b1, 2);
    push(1, 1, 1'b0, 3);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    run = 1'b1;
    tick();
    tick();
    chk("step then run step_done", step_done, 1);
    chk("step then run idle gap", busy, 0);
    tick();
    chk("step then run restarts", T, 1);
    run = 1'b0;
    drain("step then run");
    chk("step then run ncycles", ncycles, 3);

    // Counter wrap on the NW=4 build
    do_reset();
    hi_len = 16'd0; lo_len = 16'd0;
    for (int k = 1; k <= 16; k++) push(1, 1, 1'b0, k);
    run = 1'b1;
    repeat (31) tick();
    chk("narrow ncycles before wrap", w_ncycles, 15);
    tick();
    run = 1'b0;
    tick();
    chk("narrow ncycles wraps to 0", w_ncycles, 0);
    chk("wide ncycles at 16", ncycles, 16);
    drain("wrap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
